sort_host: RTL and testbench

Initiator for the sort engine's byte-stream protocol. It accepts a full N-element frame from upstream in parallel and serializes it onto data/data_vaild. It then collects the N results returned on vaild/sort_data and presents them as one parallel response frame with status flags. It sits between a frame source (CPU regs or pattern ROM) and the sort block, and replaces bench-only driving logic in synthesizable form.

---
 rtl/sort_pkg.sv | 15 +
 rtl/sort_host_if.sv | 36 +++
 rtl/sort_host.sv | 161 ++++++++++++++++
 tb/tb_sort_host.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the sort engine, its host initiator and their benches.
package sort_pkg;

    localparam int SORT_N = 6;
    localparam int SORT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        RECV,
        DONE
    } state_t;

endpackage

// File: rtl/sort_host_if.sv
// Request, sort-engine stream and response signals of the sort host, bundled with
// a host-side (master) and an environment-side (slave) view.
interface sort_host_if
    import sort_pkg::*;
#(
    parameter int N = SORT_N,
    parameter int W = SORT_W
) ();

    logic           req_valid;
    logic           req_ready;
    logic [N*W-1:0] req_data;
    logic           data_vaild;
    logic [W-1:0]   data;
    logic           vaild;
    logic [W-1:0]   sort_data;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [N*W-1:0] rsp_data;
    logic           rsp_order_err;
    logic           rsp_timeout;
    logic           stray_err;

    modport master (
        input  req_valid, req_data, vaild, sort_data, rsp_ready,
        output req_ready, data_vaild, data, rsp_valid, rsp_data,
        output rsp_order_err, rsp_timeout, stray_err
    );

    modport slave (
        output req_valid, req_data, vaild, sort_data, rsp_ready,
        input  req_ready, data_vaild, data, rsp_valid, rsp_data,
        input  rsp_order_err, rsp_timeout, stray_err
    );

endinterface

// File: rtl/sort_host.sv
// Sort engine initiator: serializes a parallel frame onto data/data_vaild, collects the
// returned stream into a parallel response and flags ordering, timeout and stray traffic.
module sort_host
    import sort_pkg::*;
#(
    parameter int N       = SORT_N,
    parameter int W       = SORT_W,
    parameter int TIMEOUT = 64,
    parameter int ASCEND  = 1
) (
    input  logic        clk,
    input  logic        rst,
    sort_host_if.master bus
);

    localparam int CW = $clog2(N + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t         state_reg,      state_next;
    logic [N*W-1:0] frame_reg,      frame_next;
    logic [CW-1:0]  send_idx_reg,   send_idx_next;
    logic [CW-1:0]  rcnt_reg,       rcnt_next;
    logic [TW-1:0]  idle_reg,       idle_next;
    logic [W-1:0]   prev_reg,       prev_next;
    logic           req_ready_reg,  req_ready_next;
    logic           data_vaild_reg, data_vaild_next;
    logic [W-1:0]   data_reg,       data_next;
    logic           rsp_valid_reg,  rsp_valid_next;
    logic [N*W-1:0] rsp_data_reg,   rsp_data_next;
    logic           order_err_reg,  order_err_next;
    logic           timeout_reg,    timeout_next;
    logic           stray_reg,      stray_next;
    logic           out_of_order;

    // Equal neighbours are legal in either direction.
    assign out_of_order = (ASCEND != 0) ? (bus.sort_data < prev_reg)
                                        : (bus.sort_data > prev_reg);

    always_comb begin
        state_next      = state_reg;
        frame_next      = frame_reg;
        send_idx_next   = send_idx_reg;
        rcnt_next       = rcnt_reg;
        idle_next       = idle_reg;
        prev_next       = prev_reg;
        req_ready_next  = 1'b0;
        data_vaild_next = 1'b0;
        data_next       = '0;
        rsp_valid_next  = rsp_valid_reg;
        rsp_data_next   = rsp_data_reg;
        order_err_next  = order_err_reg;
        timeout_next    = timeout_reg;
        stray_next      = stray_reg;

        if (bus.vaild && (state_reg == IDLE || state_reg == SEND || state_reg == DONE))
            stray_next = 1'b1;

        case (state_reg)
            IDLE: begin
                req_ready_next = 1'b1;
                if (bus.req_valid && req_ready_reg) begin
                    // Element 0 goes out immediately; the rest follow from frame_reg.
                    state_next      = SEND;
                    req_ready_next  = 1'b0;
                    frame_next      = bus.req_data;
                    data_vaild_next = 1'b1;
                    data_next       = bus.req_data[W-1:0];
                    send_idx_next   = CW'(1);
                    rcnt_next       = '0;
                    rsp_data_next   = '0;
                    order_err_next  = 1'b0;
                    timeout_next    = 1'b0;
                end
            end
            SEND: begin
                if (send_idx_reg == CW'(N)) begin
                    state_next = WAIT;
                    idle_next  = '0;
                end else begin
                    data_vaild_next = 1'b1;
                    data_next       = frame_reg[send_idx_reg*W +: W];
                    send_idx_next   = send_idx_reg + 1'b1;
                end
            end
            WAIT, RECV: begin
                if (bus.vaild) begin
                    rsp_data_next[rcnt_reg*W +: W] = bus.sort_data;
                    if (rcnt_reg != '0 && out_of_order)
                        order_err_next = 1'b1;
                    prev_next = bus.sort_data;
                    rcnt_next = rcnt_reg + 1'b1;
                    idle_next = '0;
                    if (rcnt_reg == CW'(N - 1)) begin
                        state_next     = DONE;
                        rsp_valid_next = 1'b1;
                    end else begin
                        state_next = RECV;
                    end
                end else if (idle_reg == TW'(TIMEOUT - 1)) begin
                    state_next     = DONE;
                    rsp_valid_next = 1'b1;
                    timeout_next   = 1'b1;
                end else begin
                    idle_next = idle_reg + 1'b1;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_next     = IDLE;
                    rsp_valid_next = 1'b0;
                    req_ready_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            frame_reg      <= '0;
            send_idx_reg   <= '0;
            rcnt_reg       <= '0;
            idle_reg       <= '0;
            prev_reg       <= '0;
            req_ready_reg  <= 1'b0;
            data_vaild_reg <= 1'b0;
            data_reg       <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_data_reg   <= '0;
            order_err_reg  <= 1'b0;
            timeout_reg    <= 1'b0;
            stray_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            frame_reg      <= frame_next;
            send_idx_reg   <= send_idx_next;
            rcnt_reg       <= rcnt_next;
            idle_reg       <= idle_next;
            prev_reg       <= prev_next;
            req_ready_reg  <= req_ready_next;
            data_vaild_reg <= data_vaild_next;
            data_reg       <= data_next;
            rsp_valid_reg  <= rsp_valid_next;
            rsp_data_reg   <= rsp_data_next;
            order_err_reg  <= order_err_next;
            timeout_reg    <= timeout_next;
            stray_reg      <= stray_next;
        end
    end

    assign bus.req_ready     = req_ready_reg;
    assign bus.data_vaild    = data_vaild_reg;
    assign bus.data          = data_reg;
    assign bus.rsp_valid     = rsp_valid_reg;
    assign bus.rsp_data      = rsp_data_reg;
    assign bus.rsp_order_err = order_err_reg;
    assign bus.rsp_timeout   = timeout_reg;
    assign bus.stray_err     = stray_reg;

endmodule

// File: tb/tb_sort_host.sv
// Self-checking bench for sort_host: plays the upstream source, the sort engine and the
// response sink, with expected elements and responses held in scoreboard queues.
module tb_sort_host;
    import sort_pkg::*;

    localparam int N       = SORT_N;
    localparam int W       = SORT_W;
    localparam int TIMEOUT = 64;

    typedef struct packed {
        logic [N*W-1:0] data;
        logic           oerr;
        logic           tout;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   rsp_num = 0;

    logic [W-1:0] send_q [$];
    rsp_t         rsp_q  [$];

    always #5 clk = ~clk;

    sort_host_if #(.N(N), .W(W)) bus ();

    sort_host #(.N(N), .W(W), .TIMEOUT(TIMEOUT), .ASCEND(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [N*W-1:0] pack(input logic [W-1:0] e [N]);
        logic [N*W-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*W +: W] = e[i];
        return v;
    endfunction

    // Hand a frame upstream and follow its serialization on data/data_vaild.
    task automatic drive_frame(input logic [N*W-1:0] frame, input bit hold_req, input bit ready_now);
        int waits;
        logic [W-1:0] exp_el;
        waits = 0;
        for (int i = 0; i < N; i++) send_q.push_back(frame[i*W +: W]);
        while (bus.req_ready !== 1'b1 && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        checks++;
        if (bus.req_ready !== 1'b1 || (ready_now && waits != 0)) begin
            errors++;
            $display("FAIL req_ready_wait: ready=%b after %0d cycles, required ready=1 (no wait=%0b)",
                     bus.req_ready, waits, ready_now);
        end
        bus.req_valid = 1'b1;
        bus.req_data  = frame;
        @(negedge clk);
        if (!hold_req) bus.req_valid = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL req_ready_drop: got %b required 0", bus.req_ready);
        end
        for (int i = 0; i < N; i++) begin
            exp_el = send_q.pop_front();
            checks++;
            if (bus.data_vaild !== 1'b1 || bus.data !== exp_el) begin
                errors++;
                $display("FAIL send_elem%0d: vaild=%b data=%h required vaild=1 data=%h",
                         i, bus.data_vaild, bus.data, exp_el);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.data_vaild !== 1'b0 || bus.data !== '0) begin
            errors++;
            $display("FAIL send_end: vaild=%b data=%h required vaild=0 data=00", bus.data_vaild, bus.data);
        end
    endtask

    // Act as the sort engine; the expected response is queued before driving.
    task automatic return_results(input logic [W-1:0] ret [N], input int count, input int gap, input int delay);
        rsp_t exp_rsp;
        exp_rsp.data = '0;
        exp_rsp.oerr = 1'b0;
        exp_rsp.tout = (count < N);
        for (int k = 0; k < count; k++) begin
            exp_rsp.data[k*W +: W] = ret[k];
            if (k > 0 && ret[k] < ret[k-1]) exp_rsp.oerr = 1'b1;
        end
        rsp_q.push_back(exp_rsp);
        repeat (delay) @(negedge clk);
        for (int k = 0; k < count; k++) begin
            bus.vaild     = 1'b1;
            bus.sort_data = ret[k];
            @(negedge clk);
            bus.vaild     = 1'b0;
            bus.sort_data = '0;
            if (k != count - 1) repeat (gap) @(negedge clk);
        end
    endtask

    // Wait for the response, compare against the scoreboard, hold, then hand it off.
    task automatic collect_rsp(input int hold, input int exp_latency);
        int waits;
        rsp_t exp_rsp;
        logic [N*W-1:0] first;
        waits = 0;
        while (bus.rsp_valid !== 1'b1 && waits < 2*TIMEOUT + 20) begin
            @(negedge clk);
            waits++;
        end
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rsp_valid_wait: rsp_valid=%b after %0d cycles, required 1", bus.rsp_valid, waits);
        end
        if (exp_latency >= 0) begin
            checks++;
            if (waits != exp_latency) begin
                errors++;
                $display("FAIL rsp_latency: got %0d cycles required %0d", waits, exp_latency);
            end
        end
        if (rsp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: response with empty scoreboard");
        end else begin
            exp_rsp = rsp_q.pop_front();
            checks++;
            if (bus.rsp_data !== exp_rsp.data) begin
                errors++;
                $display("FAIL rsp_data: got %h required %h", bus.rsp_data, exp_rsp.data);
            end
            checks++;
            if (bus.rsp_order_err !== exp_rsp.oerr) begin
                errors++;
                $display("FAIL rsp_order_err: got %b required %b", bus.rsp_order_err, exp_rsp.oerr);
            end
            checks++;
            if (bus.rsp_timeout !== exp_rsp.tout) begin
                errors++;
                $display("FAIL rsp_timeout: got %b required %b", bus.rsp_timeout, exp_rsp.tout);
            end
        end
        rsp_num++;
        $display("rsp %0d: data=%h order_err=%b timeout=%b after %0d cycles",
                 rsp_num, bus.rsp_data, bus.rsp_order_err, bus.rsp_timeout, waits);
        first = bus.rsp_data;
        repeat (hold) begin
            @(negedge clk);
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== first) begin
                errors++;
                $display("FAIL rsp_hold: valid=%b data=%h required valid=1 data=%h",
                         bus.rsp_valid, bus.rsp_data, first);
            end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rsp_handoff: rsp_valid=%b req_ready=%b required 0 and 1",
                     bus.rsp_valid, bus.req_ready);
        end
        if (hold > 0) bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.data_vaild, bus.data, bus.rsp_valid, bus.rsp_data,
             bus.rsp_order_err, bus.rsp_timeout, bus.stray_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b dv=%b data=%h rv=%b rdata=%h oe=%b to=%b se=%b required all 0",
                     bus.req_ready, bus.data_vaild, bus.data, bus.rsp_valid, bus.rsp_data,
                     bus.rsp_order_err, bus.rsp_timeout, bus.stray_err);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready: got %b required 0", bus.req_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_rise: got %b required 1", bus.req_ready);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] frm [N];
        logic [W-1:0] ret [N];
        frm = '{8'h05, 8'h03, 8'h09, 8'h01, 8'h07, 8'h02};
        ret = '{8'h01, 8'h02, 8'h03, 8'h05, 8'h07, 8'h09};
        drive_frame(pack(frm), 1'b0, 1'b1);
        return_results(ret, N, 0, 1);
        collect_rsp(3, 0);
    endtask

    task automatic test_order();
        logic [W-1:0] frm [N];
        logic [W-1:0] ret [N];
        frm = '{8'h09, 8'h08, 8'h07, 8'h05, 8'h02, 8'h01};
        ret = '{8'h01, 8'h02, 8'h07, 8'h05, 8'h08, 8'h09};
        drive_frame(pack(frm), 1'b0, 1'b1);
        return_results(ret, N, 0, 1);
        collect_rsp(1, 0);
        frm = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 8'h04};
        drive_frame(pack(frm), 1'b0, 1'b1);
        return_results(frm, N, 0, 1);
        collect_rsp(1, 0);
    endtask

    task automatic test_gapped_timeout();
        logic [W-1:0] frm [N];
        logic [W-1:0] ret [N];
        frm = '{8'h20, 8'h10, 8'h40, 8'h30, 8'h60, 8'h50};
        ret = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
        drive_frame(pack(frm), 1'b0, 1'b1);
        return_results(ret, N, 3, 2);
        collect_rsp(1, 0);
        ret = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        drive_frame(pack(ret), 1'b0, 1'b1);
        return_results(ret, 4, 0, 1);
        collect_rsp(1, TIMEOUT);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] frm [N];
        logic [W-1:0] ret [N];
        logic [W-1:0] t;
        bus.rsp_ready = 1'b1;
        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < N; i++) frm[i] = W'($urandom_range(0, 255));
            ret = frm;
            for (int a = 0; a < N - 1; a++)
                for (int b = 0; b < N - 1 - a; b++)
                    if (ret[b] > ret[b+1]) begin
                        t = ret[b]; ret[b] = ret[b+1]; ret[b+1] = t;
                    end
            drive_frame(pack(frm), (f < 9), (f > 0));
            return_results(ret, N, 0, 1);
            collect_rsp(0, 0);
        end
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_stray_reset();
        logic [W-1:0] frm [N];
        logic [W-1:0] ret [N];
        frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
        ret = frm;
        checks++;
        if (bus.stray_err !== 1'b0) begin
            errors++;
            $display("FAIL stray_pre: got %b required 0", bus.stray_err);
        end
        bus.vaild = 1'b1;
        bus.sort_data = 8'hAA;
        @(negedge clk);
        bus.vaild = 1'b0;
        bus.sort_data = '0;
        checks++;
        if (bus.stray_err !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL stray_set: stray=%b rsp_valid=%b required 1 and 0", bus.stray_err, bus.rsp_valid);
        end
        drive_frame(pack(frm), 1'b0, 1'b1);
        return_results(ret, N, 1, 1);
        collect_rsp(1, 0);
        checks++;
        if (bus.stray_err !== 1'b1) begin
            errors++;
            $display("FAIL stray_sticky: got %b required 1", bus.stray_err);
        end
        bus.req_valid = 1'b1;
        bus.req_data  = pack(frm);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.data_vaild !== 1'b1 || bus.data !== frm[3]) begin
            errors++;
            $display("FAIL reset_pre_elem3: vaild=%b data=%h required 1 and %h", bus.data_vaild, bus.data, frm[3]);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.data_vaild !== 1'b0 || bus.data !== '0 || bus.stray_err !== 1'b0 ||
            bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: dv=%b data=%h stray=%b ready=%b rv=%b required all 0",
                     bus.data_vaild, bus.data, bus.stray_err, bus.req_ready, bus.rsp_valid);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset2_ready_early: got %b required 0", bus.req_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset2_ready_rise: got %b required 1", bus.req_ready);
        end
        repeat (TIMEOUT + 5) begin
            @(negedge clk);
            checks++;
            if (bus.rsp_valid !== 1'b0 || bus.data_vaild !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_rsp: rsp_valid=%b data_vaild=%b required 0", bus.rsp_valid, bus.data_vaild);
            end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_data  = '0;
        bus.vaild     = 1'b0;
        bus.sort_data = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_basic();
        test_order();
        test_gapped_timeout();
        test_back_to_back();
        test_stray_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
